inv_x_count_lut_prev_next: RTL and testbench



---
 rtl/inv_x_count_lut_prev_next.sv | 117 +++++++++++
 tb/tb_inv_x_count_lut_prev_next.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/inv_x_count_lut_prev_next.sv
`default_nettype none
// ============================================================================
//  Module      : inv_x_count_lut_prev_next
//  Description : Reciprocal lookup for a sample counter. For counter value x
//                the block returns unsigned pure-fraction reciprocals 1/x,
//                1/(x+1) and 1/(x-1), each WD_REAL fractional bits. The
//                values come from a constant table that is built during
//                elaboration, so there is no divider in the datapath.
//                Entry 1 (1/1) saturates to the largest fraction.
//                Optional macro INV_X_COUNT_COMB_OUT_EN removes the output
//                registers, which gives 0-latency combinational outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_x_count_lut_prev_next #(
    parameter int SIZE_X  = 1024,
    parameter int WD_REAL = 16,
    parameter int CNT_W   = $clog2(SIZE_X) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   x_count,
    output logic [WD_REAL-1:0] inv_x_count,
    output logic [WD_REAL-1:0] inv_x_count_next,
    output logic [WD_REAL-1:0] inv_x_count_prev
);

    localparam int c_rom_depth = SIZE_X + 2;

    // Rounded reciprocal: floor((2^WD_REAL + floor(n/2)) / n), clipped to the
    // largest fraction. Non-positive n maps to 0.
    function automatic logic [WD_REAL-1:0] f_recip(input int n);
        longint unsigned num;
        longint unsigned quo;
        longint unsigned lim;
        lim = (64'd1 << WD_REAL) - 64'd1;
        if (n <= 0) begin
            return '0;
        end
        num = (64'd1 << WD_REAL) + longint'(n / 2);
        quo = num / longint'(n);
        if (quo > lim) begin
            quo = lim;
        end
        return quo[WD_REAL-1:0];
    endfunction

    // Constant table, one entry per n = 0 .. SIZE_X+1.
    logic [WD_REAL-1:0] w_rom [c_rom_depth];

    for (genvar g = 0; g < c_rom_depth; g++) begin : g_rom
        localparam logic [WD_REAL-1:0] c_val = f_recip(g);
        assign w_rom[g] = c_val;
    end

    localparam logic [CNT_W-1:0] c_size_x = CNT_W'(SIZE_X);

    logic               w_in_range;
    logic               w_is_zero;
    logic [CNT_W-1:0]   w_idx_inv;
    logic [CNT_W-1:0]   w_idx_next;
    logic [CNT_W-1:0]   w_idx_prev;
    logic [WD_REAL-1:0] w_inv;
    logic [WD_REAL-1:0] w_inv_next;
    logic [WD_REAL-1:0] w_inv_prev;

    // Three independent read ports; out-of-range counters force every output
    // to 0, and x=0 has no valid predecessor so prev is 0.
    always_comb begin
        w_in_range = (x_count <= c_size_x);
        w_is_zero  = (x_count == '0);
        // Indices are parked at 0 when out of range so the table is never
        // addressed past its end.
        w_idx_inv  = w_in_range ? x_count : '0;
        w_idx_next = w_in_range ? (x_count + CNT_W'(1)) : '0;
        w_idx_prev = (w_in_range && !w_is_zero) ? (x_count - CNT_W'(1)) : '0;
        w_inv      = w_in_range ? w_rom[w_idx_inv]  : '0;
        w_inv_next = w_in_range ? w_rom[w_idx_next] : '0;
        w_inv_prev = (w_in_range && !w_is_zero) ? w_rom[w_idx_prev] : '0;
    end

`ifdef INV_X_COUNT_COMB_OUT_EN
    // Clock and reset are kept on the port list but have no function here.
    logic w_unused;
    assign w_unused = clk ^ rst_n;

    // Zero-latency outputs for consumers that use the reciprocal in the same
    // state that updates the counter.
    always_comb begin
        inv_x_count      = w_inv;
        inv_x_count_next = w_inv_next;
        inv_x_count_prev = w_inv_prev;
    end
`else
    logic [WD_REAL-1:0] r_inv;
    logic [WD_REAL-1:0] r_inv_next;
    logic [WD_REAL-1:0] r_inv_prev;

    // Register the lookups every cycle; asynchronous reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv      <= '0;
            r_inv_next <= '0;
            r_inv_prev <= '0;
        end else begin
            r_inv      <= w_inv;
            r_inv_next <= w_inv_next;
            r_inv_prev <= w_inv_prev;
        end
    end

    assign inv_x_count      = r_inv;
    assign inv_x_count_next = r_inv_next;
    assign inv_x_count_prev = r_inv_prev;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_x_count_lut_prev_next.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_x_count_lut_prev_next
//  Description : Directed self-checking bench for inv_x_count_lut_prev_next
//                with SIZE_X=1024 and WD_REAL=16. Expected reciprocals are
//                hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_x_count_lut_prev_next;

    localparam int SIZE_X  = 1024;
    localparam int WD_REAL = 16;
    localparam int CNT_W   = $clog2(SIZE_X) + 1;

    logic               clk;
    logic               rst_n;
    logic [CNT_W-1:0]   x_count;
    logic [WD_REAL-1:0] inv_x_count;
    logic [WD_REAL-1:0] inv_x_count_next;
    logic [WD_REAL-1:0] inv_x_count_prev;

    int n_checks = 0;
    int n_errors = 0;

    inv_x_count_lut_prev_next #(
        .SIZE_X  (SIZE_X),
        .WD_REAL (WD_REAL)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .x_count          (x_count),
        .inv_x_count      (inv_x_count),
        .inv_x_count_next (inv_x_count_next),
        .inv_x_count_prev (inv_x_count_prev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic t_check(input string tag, input logic [WD_REAL-1:0] got,
                           input logic [WD_REAL-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic t_check3(input string tag, input logic [WD_REAL-1:0] e_inv,
                            input logic [WD_REAL-1:0] e_next,
                            input logic [WD_REAL-1:0] e_prev);
        t_check({tag, ".inv"},  inv_x_count,      e_inv);
        t_check({tag, ".next"}, inv_x_count_next, e_next);
        t_check({tag, ".prev"}, inv_x_count_prev, e_prev);
    endtask

`ifndef INV_X_COUNT_COMB_OUT_EN
    // Drive x on the falling edge, then check one rising edge later.
    task automatic t_lookup(input string tag, input int x,
                            input logic [WD_REAL-1:0] e_inv,
                            input logic [WD_REAL-1:0] e_next,
                            input logic [WD_REAL-1:0] e_prev);
        @(negedge clk);
        x_count = CNT_W'(x);
        @(posedge clk);
        #1;
        t_check3(tag, e_inv, e_next, e_prev);
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        x_count = CNT_W'(2);
`ifdef INV_X_COUNT_COMB_OUT_EN
        #1;
        t_check3("comb_x2_rst", 16'h8000, 16'h5555, 16'hFFFF);
        x_count = CNT_W'(4);
        #1;
        t_check3("comb_x4_rst", 16'h4000, 16'h3333, 16'h5555);
        rst_n = 1'b1;
        x_count = CNT_W'(2);
        #1;
        t_check3("comb_x2", 16'h8000, 16'h5555, 16'hFFFF);
        x_count = CNT_W'(4);
        #1;
        t_check3("comb_x4", 16'h4000, 16'h3333, 16'h5555);
        x_count = CNT_W'(1025);
        #1;
        t_check3("comb_x1025", 16'h0000, 16'h0000, 16'h0000);
`else
        #3;
        t_check3("reset", 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        t_check3("reset_clk", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t_check3("first_x2", 16'h8000, 16'h5555, 16'hFFFF);

        t_lookup("x0", 0, 16'h0000, 16'hFFFF, 16'h0000);
        t_lookup("x1", 1, 16'hFFFF, 16'h8000, 16'h0000);

        // Latency: right after x changes to 3 the outputs still show x=1.
        @(negedge clk);
        x_count = CNT_W'(3);
        #1;
        t_check3("lag_x3", 16'hFFFF, 16'h8000, 16'h0000);
        @(posedge clk);
        #1;
        t_check3("x3", 16'h5555, 16'h4000, 16'h8000);
        t_lookup("x4", 4, 16'h4000, 16'h3333, 16'h5555);

        t_lookup("x1023", 1023, 16'h0040, 16'h0040, 16'h0040);
        t_lookup("x1024", 1024, 16'h0040, 16'h0040, 16'h0040);
        t_lookup("x1025", 1025, 16'h0000, 16'h0000, 16'h0000);
        t_lookup("x2047", 2047, 16'h0000, 16'h0000, 16'h0000);
        t_lookup("x4b",   4,    16'h4000, 16'h3333, 16'h5555);

        // Asynchronous reset between edges clears outputs at once.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        t_check3("async_rst", 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        t_check3("rst_hold", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        t_check3("rst_release", 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        t_check3("after_rst", 16'h4000, 16'h3333, 16'h5555);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
